ms_timer_scheduler: RTL and testbench

//  Shares one external 1 ms tick generator between NUM_CH requesters, each needing a

---
 rtl/ms_timer_scheduler.sv | 156 +++++++++++++++
 tb/tb_ms_timer_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ms_timer_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ms_timer_scheduler                                                          |
// | Round-robin loader for NUM_CH millisecond countdowns sharing one tick       |
// | source. Optional feature macro: PERIODIC_RELOAD_EN (auto-reload on expiry). |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module ms_timer_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int DELAY_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         req,
   input  logic [NUM_CH*DELAY_W-1:0] delay_ms,
   input  logic [NUM_CH-1:0]         cancel,
   input  logic                      ms_tick,
`ifdef PERIODIC_RELOAD_EN
   input  logic [NUM_CH-1:0]         periodic,
`endif
   output logic                      tick_en,
   output logic [NUM_CH-1:0]         ack,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH-1:0]         done
);

   localparam int                 c_ptr_w   = $clog2(NUM_CH);
   localparam logic [DELAY_W-1:0] c_cnt_one = DELAY_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_e;

   ch_state_e          state_q  [NUM_CH];
   ch_state_e          state_d  [NUM_CH];
   logic [DELAY_W-1:0] cnt_q    [NUM_CH];
   logic [DELAY_W-1:0] cnt_d    [NUM_CH];
   logic [DELAY_W-1:0] load_val [NUM_CH];
   logic [NUM_CH-1:0]  ack_q, ack_d;
   logic [NUM_CH-1:0]  done_q, done_d;
   logic [NUM_CH-1:0]  pending, grant;
   logic [c_ptr_w-1:0] ptr_q, ptr_d;
   logic               tick_en_q, tick_en_d;
   logic               tick_live;
   logic               found;
   int                 idx;
`ifdef PERIODIC_RELOAD_EN
   logic [NUM_CH-1:0]  per_q, per_d;
   logic [DELAY_W-1:0] reload_q [NUM_CH];
   logic [DELAY_W-1:0] reload_d [NUM_CH];
`endif

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
         // A zero delay is treated as one millisecond.
         assign load_val[g] = (delay_ms[g*DELAY_W +: DELAY_W] == '0) ?
                              c_cnt_one : delay_ms[g*DELAY_W +: DELAY_W];
         assign busy[g]     = (state_q[g] == ST_RUN);
      end
   endgenerate

   // A req still high while its ack shows is the old request; cancel defers a grant.
   assign pending   = req & ~ack_q & ~cancel;
   assign tick_live = ms_tick & tick_en_q;

   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (int'(ptr_q) + k) % NUM_CH;
         if (!found && pending[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
            ptr_d      = (idx == NUM_CH - 1) ? '0 : c_ptr_w'(idx + 1);
         end
      end
   end

   always_comb begin
      ack_d     = grant;
      tick_en_d = |busy;
      done_d    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
`ifdef PERIODIC_RELOAD_EN
         per_d[i]    = per_q[i];
         reload_d[i] = reload_q[i];
`endif
         if (cancel[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
         end else if (grant[i]) begin
            state_d[i] = ST_RUN;
            cnt_d[i]   = load_val[i];
`ifdef PERIODIC_RELOAD_EN
            per_d[i]    = periodic[i];
            reload_d[i] = load_val[i];
`endif
         end else if (state_q[i] == ST_RUN && tick_live && cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - c_cnt_one;
            if (cnt_q[i] == c_cnt_one) begin
               done_d[i] = 1'b1;
`ifdef PERIODIC_RELOAD_EN
               if (per_q[i]) begin
                  cnt_d[i] = reload_q[i];
               end else begin
                  state_d[i] = ST_IDLE;
               end
`else
               state_d[i] = ST_IDLE;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ack_q     <= '0;
         done_q    <= '0;
         ptr_q     <= '0;
         tick_en_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
`ifdef PERIODIC_RELOAD_EN
            per_q[i]    <= 1'b0;
            reload_q[i] <= '0;
`endif
         end
      end else begin
         ack_q     <= ack_d;
         done_q    <= done_d;
         ptr_q     <= ptr_d;
         tick_en_q <= tick_en_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
`ifdef PERIODIC_RELOAD_EN
            per_q[i]    <= per_d[i];
            reload_q[i] <= reload_d[i];
`endif
         end
      end
   end

   assign tick_en = tick_en_q;
   assign ack     = ack_q;
   assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ms_timer_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ms_timer_scheduler                                                       |
// | Scoreboard bench: reference model predicts every cycle's outputs.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_ms_timer_scheduler;

   localparam int NUM_CH  = 4;
   localparam int DELAY_W = 16;

   typedef struct packed {
      logic [NUM_CH-1:0] ack;
      logic [NUM_CH-1:0] busy;
      logic [NUM_CH-1:0] done;
      logic              tick_en;
   } exp_t;

   logic                      clk = 1'b0;
   logic                      rst = 1'b0;
   logic [NUM_CH-1:0]         req = '0;
   logic [NUM_CH*DELAY_W-1:0] delay_ms = '0;
   logic [NUM_CH-1:0]         cancel = '0;
   logic                      ms_tick = 1'b0;
`ifdef PERIODIC_RELOAD_EN
   logic [NUM_CH-1:0]         periodic = '0;
`endif
   logic                      tick_en;
   logic [NUM_CH-1:0]         ack, busy, done;

   int vectors     = 0;
   int miscompares = 0;
   exp_t exp_q[$];

   // Reference model: remaining milliseconds per channel plus round-robin pointer.
   int                m_rem    [NUM_CH];
   int                m_reload [NUM_CH];
   bit                m_run    [NUM_CH];
   bit                m_per    [NUM_CH];
   int                m_ptr = 0;
   bit                m_tick_en = 1'b0;
   logic [NUM_CH-1:0] m_ack  = '0;
   logic [NUM_CH-1:0] m_done = '0;

   ms_timer_scheduler #(.NUM_CH(NUM_CH), .DELAY_W(DELAY_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .delay_ms (delay_ms),
      .cancel   (cancel),
      .ms_tick  (ms_tick),
`ifdef PERIODIC_RELOAD_EN
      .periodic (periodic),
`endif
      .tick_en  (tick_en),
      .ack      (ack),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic model();
      int  g;
      int  c;
      int  d;
      bit  any;
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_rem[i] = 0; m_run[i] = 0; m_per[i] = 0; m_reload[i] = 0;
         end
         m_ptr = 0; m_tick_en = 0; m_ack = '0; m_done = '0;
      end else begin
         any = 0;
         for (int i = 0; i < NUM_CH; i++) any |= m_run[i];
         g = -1;
         for (int k = 0; k < NUM_CH; k++) begin
            c = (m_ptr + k) % NUM_CH;
            if (g < 0 && req[c] && !m_ack[c] && !cancel[c]) g = c;
         end
         m_done = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            d = int'(delay_ms[i*DELAY_W +: DELAY_W]);
            if (cancel[i]) begin
               m_run[i] = 0; m_rem[i] = 0;
            end else if (i == g) begin
               m_run[i]    = 1;
               m_rem[i]    = (d == 0) ? 1 : d;
               m_reload[i] = m_rem[i];
`ifdef PERIODIC_RELOAD_EN
               m_per[i]    = periodic[i];
`else
               m_per[i]    = 0;
`endif
            end else if (m_run[i] && ms_tick && m_tick_en && m_rem[i] > 0) begin
               m_rem[i] = m_rem[i] - 1;
               if (m_rem[i] == 0) begin
                  m_done[i] = 1'b1;
                  if (m_per[i]) m_rem[i] = m_reload[i];
                  else          m_run[i] = 0;
               end
            end
         end
         m_ack = '0;
         if (g >= 0) begin
            m_ack[g] = 1'b1;
            m_ptr    = (g + 1) % NUM_CH;
         end
         m_tick_en = any;
      end
   endtask

   // One clock: model the edge, queue the prediction, then release pulses and acked reqs.
   task automatic step();
      logic [NUM_CH-1:0] prev_ack;
      exp_t              e;
      @(posedge clk);
      prev_ack = m_ack;
      model();
      e.ack     = m_ack;
      e.done    = m_done;
      e.tick_en = m_tick_en;
      for (int i = 0; i < NUM_CH; i++) e.busy[i] = m_run[i];
      exp_q.push_back(e);
      #1;
      req     = req & ~prev_ack;
      cancel  = '0;
      ms_tick = 1'b0;
   endtask

   task automatic run(input int n, input int tick_every);
      for (int j = 0; j < n; j++) begin
         if (tick_every > 0 && (j % tick_every) == tick_every - 1) ms_tick = 1'b1;
         step();
      end
   endtask

   task automatic set_req(input int ch, input int d);
      req[ch] = 1'b1;
      delay_ms[ch*DELAY_W +: DELAY_W] = DELAY_W'(d);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if ({ack, busy, done, tick_en} !== e) begin
            miscompares++;
            $display("FAIL outputs @%0t: got ack=%b busy=%b done=%b tick_en=%b, want ack=%b busy=%b done=%b tick_en=%b",
                     $time, ack, busy, done, tick_en, e.ack, e.busy, e.done, e.tick_en);
         end
      end
   end

   initial begin
      // Reset held for three cycles with no requests.
      repeat (3) step();
      rst = 1'b1;
      // Single channel, delay 3.
      set_req(1, 3);
      run(14, 3);
      // All channels at once, delays 5..8.
      for (int c = 0; c < NUM_CH; c++) set_req(c, 5 + c);
      run(40, 3);
      // Cancel coincides with the expiring tick.
      set_req(2, 1);
      run(3, 0);
      ms_tick   = 1'b1;
      cancel[2] = 1'b1;
      step();
      run(4, 0);
      // Zero delay, then restart of a running channel.
      set_req(0, 0);
      set_req(3, 3);
      run(4, 0);
      ms_tick = 1'b1;
      step();
      set_req(3, 10);
      run(40, 3);
      // Load coinciding with a tick, then reset mid-run.
      set_req(0, 20);
      run(3, 0);
      set_req(1, 4);
      ms_tick = 1'b1;
      step();
      run(8, 3);
      rst = 1'b0;
      run(2, 0);
      rst = 1'b1;
      run(5, 3);
`ifdef PERIODIC_RELOAD_EN
      periodic[0] = 1'b1;
      set_req(0, 2);
      run(12, 2);
      cancel[0] = 1'b1;
      step();
      run(6, 2);
      periodic = '0;
`endif
      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!req[c] && $urandom_range(7) == 0) set_req(c, int'($urandom_range(5)));
            if ($urandom_range(19) == 0) cancel[c] = 1'b1;
`ifdef PERIODIC_RELOAD_EN
            if (!req[c]) periodic[c] = $urandom_range(1) == 1;
`endif
         end
         ms_tick = $urandom_range(2) == 0;
         rst     = $urandom_range(199) != 0;
         step();
      end
      rst = 1'b1;
      run(4, 0);
      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
